// File: rtl/pdp1_mem_arbiter.sv
// pdp1_mem_arbiter: shares the single core-memory port between the CPU and two
// cycle-break data channels. One registered grant per cycle. Priority order is a
// pending CPU lock, then the starvation override, then the channels in round-robin
// order, then the CPU. Accesses to memory fields that are not installed fault.
// Optional feature: define PDP1_ARB_STARVE_EN to add the CPU starvation guard.
module pdp1_mem_arbiter #(
    parameter int unsigned UNITS      = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_lock,
    input  logic [11:0] cpu_adr,
    input  logic [3:0]  cpu_unit,
    input  logic [17:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        cpu_rvalid,
    output logic [17:0] cpu_rdata,
    input  logic [1:0]  ch_req,
    input  logic [1:0]  ch_we,
    input  logic [23:0] ch_adr,
    input  logic [7:0]  ch_unit,
    input  logic [35:0] ch_wdata,
    output logic [1:0]  ch_ack,
    output logic [1:0]  ch_err,
    output logic [1:0]  ch_rvalid,
    output logic [17:0] ch_rdata,
    output logic        mm_we,
    output logic [11:0] mm_adr,
    output logic [3:0]  mm_unit,
    output logic [17:0] mm_din,
    input  logic [17:0] mm_dout
);

    typedef enum logic [1:0] {OwnNone, OwnCpu, OwnCh0, OwnCh1} owner_e;

    owner_e      win;
    logic        cpu_elig;
    logic [1:0]  ch_elig;
    logic        sel_we;
    logic [11:0] sel_adr;
    logic [3:0]  sel_unit;
    logic [17:0] sel_wdata;
    logic        granted;
    logic        fault;
    logic        starve_hit;

    logic        cpu_ack_q, cpu_ack_d;
    logic        cpu_err_q, cpu_err_d;
    logic [1:0]  ch_ack_q, ch_ack_d;
    logic [1:0]  ch_err_q, ch_err_d;
    logic        mm_we_q, mm_we_d;
    logic [11:0] mm_adr_q, mm_adr_d;
    logic [3:0]  mm_unit_q, mm_unit_d;
    logic [17:0] mm_din_q, mm_din_d;
    logic        rr_q, rr_d;
    logic        lock_q, lock_d;
    owner_e      owner_q, owner_d;
    owner_e      rd_owner_q, rd_owner_d;
    logic [17:0] cpu_rdata_q, cpu_rdata_d;
    logic [17:0] ch_rdata_q, ch_rdata_d;

`ifdef PDP1_ARB_STARVE_EN
    localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

    assign starve_hit = (32'(starve_cnt_q) == STARVE_MAX);

    // Count channel grants issued while the CPU is kept waiting.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (win == OwnCpu || !cpu_req) begin
            starve_cnt_d = '0;
        end else if ((win == OwnCh0 || win == OwnCh1) && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    // Pick the winner among requesters not acked in the current cycle.
    always_comb begin
        cpu_elig = cpu_req & ~cpu_ack_q;
        ch_elig  = ch_req & ~ch_ack_q;
        win      = OwnNone;
        if (lock_q) begin
            // Channels are locked out until the CPU completes its locked pair.
            if (cpu_elig) win = OwnCpu;
        end else if (starve_hit && cpu_elig) begin
            win = OwnCpu;
        end else if (ch_elig[rr_q]) begin
            win = rr_q ? OwnCh1 : OwnCh0;
        end else if (ch_elig[~rr_q]) begin
            win = rr_q ? OwnCh0 : OwnCh1;
        end else if (cpu_elig) begin
            win = OwnCpu;
        end
    end

    // Route the winner's request fields.
    always_comb begin
        sel_we    = 1'b0;
        sel_adr   = '0;
        sel_unit  = '0;
        sel_wdata = '0;
        case (win)
            OwnCpu: begin
                sel_we    = cpu_we;
                sel_adr   = cpu_adr;
                sel_unit  = cpu_unit;
                sel_wdata = cpu_wdata;
            end
            OwnCh0: begin
                sel_we    = ch_we[0];
                sel_adr   = ch_adr[11:0];
                sel_unit  = ch_unit[3:0];
                sel_wdata = ch_wdata[17:0];
            end
            OwnCh1: begin
                sel_we    = ch_we[1];
                sel_adr   = ch_adr[23:12];
                sel_unit  = ch_unit[7:4];
                sel_wdata = ch_wdata[35:18];
            end
            default: ;
        endcase
        granted = (win != OwnNone);
        fault   = granted && (32'(sel_unit) >= UNITS);
    end

    // Next-state for grant pulses, memory port, pointer, lock and read ownership.
    always_comb begin
        cpu_ack_d  = (win == OwnCpu);
        ch_ack_d   = {win == OwnCh1, win == OwnCh0};
        cpu_err_d  = cpu_ack_d & fault;
        ch_err_d   = ch_ack_d & {2{fault}};
        mm_we_d    = 1'b0;
        mm_adr_d   = mm_adr_q;
        mm_unit_d  = mm_unit_q;
        mm_din_d   = mm_din_q;
        owner_d    = OwnNone;
        if (granted && !fault) begin
            mm_we_d   = sel_we;
            mm_adr_d  = sel_adr;
            mm_unit_d = sel_unit;
            mm_din_d  = sel_wdata;
            if (!sel_we) owner_d = win;
        end
        // Data returns the cycle after the address, so ownership trails by one stage.
        rd_owner_d = owner_q;
        rr_d       = rr_q;
        if (win == OwnCh0) begin
            rr_d = 1'b1;
        end else if (win == OwnCh1) begin
            rr_d = 1'b0;
        end
        lock_d = lock_q;
        if (win == OwnCpu) begin
            lock_d = cpu_lock;
        end else if (!cpu_req && !cpu_ack_q) begin
            lock_d = 1'b0;
        end
        cpu_rdata_d = cpu_rdata;
        ch_rdata_d  = ch_rdata;
    end

    // State registers; reset discards any read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            ch_ack_q    <= '0;
            ch_err_q    <= '0;
            mm_we_q     <= 1'b0;
            mm_adr_q    <= '0;
            mm_unit_q   <= '0;
            mm_din_q    <= '0;
            rr_q        <= 1'b0;
            lock_q      <= 1'b0;
            owner_q     <= OwnNone;
            rd_owner_q  <= OwnNone;
            cpu_rdata_q <= '0;
            ch_rdata_q  <= '0;
        end else begin
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            ch_ack_q    <= ch_ack_d;
            ch_err_q    <= ch_err_d;
            mm_we_q     <= mm_we_d;
            mm_adr_q    <= mm_adr_d;
            mm_unit_q   <= mm_unit_d;
            mm_din_q    <= mm_din_d;
            rr_q        <= rr_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            rd_owner_q  <= rd_owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            ch_rdata_q  <= ch_rdata_d;
        end
    end

    assign cpu_ack    = cpu_ack_q;
    assign cpu_err    = cpu_err_q;
    assign ch_ack     = ch_ack_q;
    assign ch_err     = ch_err_q;
    assign mm_we      = mm_we_q;
    assign mm_adr     = mm_adr_q;
    assign mm_unit    = mm_unit_q;
    assign mm_din     = mm_din_q;
    assign cpu_rvalid = (rd_owner_q == OwnCpu);
    assign ch_rvalid  = {rd_owner_q == OwnCh1, rd_owner_q == OwnCh0};
    // Read data passes straight through while valid and is held afterwards.
    assign cpu_rdata  = cpu_rvalid ? mm_dout : cpu_rdata_q;
    assign ch_rdata   = (|ch_rvalid) ? mm_dout : ch_rdata_q;

endmodule

// File: tb/tb_pdp1_mem_arbiter.sv
// Self-checking bench for pdp1_mem_arbiter: directed scenarios plus a randomized
// run checked against a priority-list reference model and a reference memory.
module tb_pdp1_mem_arbiter;

    localparam int unsigned UNITS      = 1;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk, rst;
    logic        cpu_req, cpu_we, cpu_lock;
    logic [11:0] cpu_adr;
    logic [3:0]  cpu_unit;
    logic [17:0] cpu_wdata;
    logic        cpu_ack, cpu_err, cpu_rvalid;
    logic [17:0] cpu_rdata;
    logic [1:0]  ch_req, ch_we;
    logic [23:0] ch_adr;
    logic [7:0]  ch_unit;
    logic [35:0] ch_wdata;
    logic [1:0]  ch_ack, ch_err, ch_rvalid;
    logic [17:0] ch_rdata;
    logic        mm_we;
    logic [11:0] mm_adr;
    logic [3:0]  mm_unit;
    logic [17:0] mm_din, mm_dout;

    int n_run  = 0;
    int n_fail = 0;

    // Memory stub: synchronous read, data valid the cycle after the address.
    logic [17:0] mem [4096];
    logic        pre_we = 1'b0;
    logic [11:0] pre_adr = '0;
    logic [17:0] pre_dat = '0;
    logic [17:0] ref_mem [16];

    pdp1_mem_arbiter #(.UNITS(UNITS), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock), .cpu_adr(cpu_adr),
        .cpu_unit(cpu_unit), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ch_req(ch_req), .ch_we(ch_we), .ch_adr(ch_adr), .ch_unit(ch_unit),
        .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_err(ch_err), .ch_rvalid(ch_rvalid),
        .ch_rdata(ch_rdata),
        .mm_we(mm_we), .mm_adr(mm_adr), .mm_unit(mm_unit), .mm_din(mm_din),
        .mm_dout(mm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) mem[pre_adr] <= pre_dat;
        else if (mm_we) mem[mm_adr] <= mm_din;
        mm_dout <= mem[mm_adr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_adr = '0; cpu_unit = '0; cpu_wdata = '0;
        ch_req = '0; ch_we = '0; ch_adr = '0; ch_unit = '0; ch_wdata = '0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [17:0] obs [12];
        string nm [12] = '{"cpu_ack", "cpu_err", "cpu_rvalid", "cpu_rdata", "ch_ack",
                           "ch_err", "ch_rvalid", "ch_rdata", "mm_we", "mm_adr",
                           "mm_unit", "mm_din"};
        apply_reset();
        obs[0] = 18'(cpu_ack);  obs[1] = 18'(cpu_err);  obs[2] = 18'(cpu_rvalid);
        obs[3] = cpu_rdata;     obs[4] = 18'(ch_ack);   obs[5] = 18'(ch_err);
        obs[6] = 18'(ch_rvalid); obs[7] = ch_rdata;     obs[8] = 18'(mm_we);
        obs[9] = 18'(mm_adr);   obs[10] = 18'(mm_unit); obs[11] = mm_din;
        for (int i = 0; i < 12; i++) begin
            n_run++;
            if (obs[i] !== 18'd0) begin
                n_fail++;
                $display("FAIL reset %s got %0h want 0", nm[i], obs[i]);
            end
        end
    endtask

    task automatic test_cpu_read();
        apply_reset();
        pre_we = 1'b1; pre_adr = 12'o0100; pre_dat = 18'o123456;
        tick();
        pre_we = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_adr = 12'o0100; cpu_unit = 4'd0;
        tick();
        n_run++;
        if ({cpu_ack, ch_ack, mm_we, mm_adr} !== {1'b1, 2'b00, 1'b0, 12'o0100}) begin
            n_fail++;
            $display("FAIL cpu_read ack/mm got ack=%b ch=%b we=%b adr=%o want 1 00 0 100",
                     cpu_ack, ch_ack, mm_we, mm_adr);
        end
        cpu_req = 0;
        tick();
        n_run++;
        if ({cpu_rvalid, cpu_ack, cpu_rdata} !== {1'b1, 1'b0, 18'o123456}) begin
            n_fail++;
            $display("FAIL cpu_read data got rvalid=%b ack=%b rdata=%o want 1 0 123456",
                     cpu_rvalid, cpu_ack, cpu_rdata);
        end
        tick();
        n_run++;
        if (cpu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_read rvalid_width got %b want 0", cpu_rvalid);
        end
    endtask

    task automatic test_channel_rr();
        int par = 0;
        int run = 0;
        logic [2:0] exp_g;
        apply_reset();
        cpu_req = 1; ch_req = 2'b11;
        for (int k = 0; k < 20; k++) begin
            tick();
`ifdef PDP1_ARB_STARVE_EN
            if (run == int'(STARVE_MAX)) begin
                exp_g = 3'b001;
                run = 0;
            end else begin
                exp_g = (par != 0) ? 3'b100 : 3'b010;
                par ^= 1;
                run++;
            end
`else
            exp_g = (par != 0) ? 3'b100 : 3'b010;
            par ^= 1;
`endif
            n_run++;
            if ({ch_ack, cpu_ack} !== exp_g) begin
                n_fail++;
                $display("FAIL channel_rr grant %0d got {ch,cpu}=%b want %b",
                         k, {ch_ack, cpu_ack}, exp_g);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_lock();
        apply_reset();
        cpu_req = 1; cpu_lock = 1; cpu_we = 0; cpu_adr = 12'd6;
        tick();
        n_run++;
        if ({cpu_ack, ch_ack} !== 3'b100) begin
            n_fail++;
            $display("FAIL lock first_ack got %b want 100", {cpu_ack, ch_ack});
        end
        // Channel starts asking just as the locked read is acked; CPU keeps req high.
        ch_req = 2'b01; ch_adr[11:0] = 12'd5;
        cpu_lock = 0; cpu_we = 1; cpu_adr = 12'd7; cpu_wdata = 18'o777777;
        tick();
        n_run++;
        if ({cpu_ack, ch_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL lock gap got %b want 000", {cpu_ack, ch_ack});
        end
        tick();
        n_run++;
        if ({cpu_ack, ch_ack, mm_we, mm_din} !== {3'b100, 1'b1, 18'o777777}) begin
            n_fail++;
            $display("FAIL lock write got ack=%b we=%b din=%o want 100 1 777777",
                     {cpu_ack, ch_ack}, mm_we, mm_din);
        end
        cpu_req = 0;
        tick();
        n_run++;
        if ({cpu_ack, ch_ack} !== 3'b001) begin
            n_fail++;
            $display("FAIL lock release got %b want 001", {cpu_ack, ch_ack});
        end
        idle();
        tick();
    endtask

    task automatic test_fault();
        apply_reset();
        ch_req = 2'b01; ch_we = 2'b01; ch_adr[11:0] = 12'o0033; ch_wdata[17:0] = 18'o111111;
        tick();
        n_run++;
        if ({ch_ack, mm_we} !== 3'b011) begin
            n_fail++;
            $display("FAIL fault setup got ch_ack=%b we=%b want 01 1", ch_ack, mm_we);
        end
        ch_req = 2'b10; ch_we = 2'b10; ch_adr[23:12] = 12'o0044; ch_unit[7:4] = 4'd1;
        ch_wdata[35:18] = 18'o222222;
        tick();
        n_run++;
        if ({ch_ack, ch_err, mm_we} !== 5'b10100) begin
            n_fail++;
            $display("FAIL fault pulse got ack=%b err=%b we=%b want 10 10 0",
                     ch_ack, ch_err, mm_we);
        end
        n_run++;
        if ({mm_adr, mm_unit, mm_din} !== {12'o0033, 4'd0, 18'o111111}) begin
            n_fail++;
            $display("FAIL fault hold got adr=%o unit=%0d din=%o want 33 0 111111",
                     mm_adr, mm_unit, mm_din);
        end
        ch_req = 2'b00;
        tick();
        n_run++;
        if ({ch_rvalid, ch_ack, ch_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL fault after got rv=%b ack=%b err=%b want 0",
                     ch_rvalid, ch_ack, ch_err);
        end
        cpu_req = 1; cpu_we = 0; cpu_unit = 4'hf; cpu_adr = 12'o0055;
        tick();
        n_run++;
        if ({cpu_ack, cpu_err, mm_adr} !== {2'b11, 12'o0033}) begin
            n_fail++;
            $display("FAIL fault cpu_read got ack=%b err=%b adr=%o want 1 1 33",
                     cpu_ack, cpu_err, mm_adr);
        end
        cpu_req = 0;
        tick();
        n_run++;
        if ({cpu_rvalid, cpu_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL fault cpu_rvalid got rv=%b err=%b want 0 0", cpu_rvalid, cpu_err);
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        cpu_req = 1; cpu_we = 0; cpu_adr = 12'o0100; cpu_unit = 4'd0;
        tick();
        n_run++;
        if (cpu_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid ack got %b want 1", cpu_ack);
        end
        rst = 1'b0;
        cpu_req = 0;
        #1;
        n_run++;
        if ({cpu_ack, cpu_rvalid, mm_adr} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid async got ack=%b rv=%b adr=%o want 0",
                     cpu_ack, cpu_rvalid, mm_adr);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_run++;
            if ({cpu_rvalid, cpu_ack, cpu_rdata, mm_adr, mm_we} !== 33'd0) begin
                n_fail++;
                $display("FAIL reset_mid after %0d got rv=%b ack=%b rdata=%o adr=%o we=%b",
                         k, cpu_rvalid, cpu_ack, cpu_rdata, mm_adr, mm_we);
            end
        end
    endtask

    task automatic test_random();
        logic        act [3];
        logic        we [3];
        logic [11:0] adr [3];
        logic [3:0]  unit [3];
        logic [17:0] wd [3];
        logic        lk;
        logic [2:0]  m_ack, exp_err, exp_rv, rv_stage;
        logic        exp_we, m_lock, prev_cpu_mask, starve;
        logic [11:0] exp_adr;
        logic [3:0]  exp_unit;
        logic [17:0] exp_din, exp_rd, rd_stage;
        int          m_ptr, m_cnt, win;
        int          cand [$];
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            pre_we = 1'b1; pre_adr = 12'(i); pre_dat = 18'($urandom);
            ref_mem[i] = pre_dat;
            tick();
        end
        pre_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            act[i] = 0; we[i] = 0; adr[i] = '0; unit[i] = '0; wd[i] = '0;
        end
        lk = 0; m_ack = '0; exp_err = '0; exp_rv = '0; rv_stage = '0; exp_we = 0;
        m_lock = 0; exp_adr = '0; exp_unit = '0; exp_din = '0; exp_rd = '0; rd_stage = '0;
        m_ptr = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            n_run++;
            if ({ch_ack, cpu_ack} !== m_ack) begin
                n_fail++;
                $display("FAIL random ack cyc %0d got %b want %b", cyc, {ch_ack, cpu_ack}, m_ack);
            end
            n_run++;
            if ({ch_err, cpu_err} !== exp_err) begin
                n_fail++;
                $display("FAIL random err cyc %0d got %b want %b", cyc, {ch_err, cpu_err}, exp_err);
            end
            n_run++;
            if ({mm_we, mm_adr, mm_unit} !== {exp_we, exp_adr, exp_unit}) begin
                n_fail++;
                $display("FAIL random mm cyc %0d got we=%b adr=%o unit=%0d want %b %o %0d",
                         cyc, mm_we, mm_adr, mm_unit, exp_we, exp_adr, exp_unit);
            end
            if (exp_we) begin
                n_run++;
                if (mm_din !== exp_din) begin
                    n_fail++;
                    $display("FAIL random din cyc %0d got %o want %o", cyc, mm_din, exp_din);
                end
            end
            n_run++;
            if ({ch_rvalid, cpu_rvalid} !== exp_rv) begin
                n_fail++;
                $display("FAIL random rvalid cyc %0d got %b want %b",
                         cyc, {ch_rvalid, cpu_rvalid}, exp_rv);
            end
            if (exp_rv[0]) begin
                n_run++;
                if (cpu_rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL random cpu_rdata cyc %0d got %o want %o", cyc, cpu_rdata, exp_rd);
                end
            end
            if (exp_rv[2:1] != 2'b00) begin
                n_run++;
                if (ch_rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL random ch_rdata cyc %0d got %o want %o", cyc, ch_rdata, exp_rd);
                end
            end
            // Requester protocol: hold until acked, then maybe issue a new request.
            for (int i = 0; i < 3; i++) begin
                if (m_ack[i]) act[i] = 0;
                if (!act[i] && $urandom_range(0, 1) == 1) begin
                    act[i]  = 1;
                    we[i]   = 1'($urandom_range(0, 1));
                    adr[i]  = 12'($urandom_range(0, 15));
                    unit[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
                    wd[i]   = 18'($urandom);
                    if (i == 0) lk = ($urandom_range(0, 3) == 0);
                end
            end
            cpu_req = act[0]; cpu_we = we[0]; cpu_lock = lk; cpu_adr = adr[0];
            cpu_unit = unit[0]; cpu_wdata = wd[0];
            ch_req = {act[2], act[1]}; ch_we = {we[2], we[1]}; ch_adr = {adr[2], adr[1]};
            ch_unit = {unit[2], unit[1]}; ch_wdata = {wd[2], wd[1]};
            // Reference model: first eligible requester in the current priority list.
`ifdef PDP1_ARB_STARVE_EN
            starve = (m_cnt == int'(STARVE_MAX));
`else
            starve = 1'b0;
`endif
            if (m_lock) cand = '{0};
            else if (starve) cand = '{0, 1 + m_ptr, 2 - m_ptr};
            else cand = '{1 + m_ptr, 2 - m_ptr, 0};
            win = -1;
            foreach (cand[j]) begin
                if (win < 0 && act[cand[j]] && !m_ack[cand[j]]) win = cand[j];
            end
            prev_cpu_mask = m_ack[0];
            m_ack = '0; exp_err = '0; exp_we = 0;
            exp_rv = rv_stage; exp_rd = rd_stage; rv_stage = '0;
            if (win >= 0) begin
                m_ack[win] = 1'b1;
                if (unit[win] >= UNITS) begin
                    exp_err[win] = 1'b1;
                end else begin
                    exp_adr = adr[win]; exp_unit = unit[win];
                    if (we[win]) begin
                        exp_we = 1; exp_din = wd[win];
                        ref_mem[adr[win][3:0]] = wd[win];
                    end else begin
                        rv_stage[win] = 1'b1;
                        rd_stage = ref_mem[adr[win][3:0]];
                    end
                end
            end
            if (win == 0) m_lock = lk;
            else if (!act[0] && !prev_cpu_mask) m_lock = 0;
            if (win == 1) m_ptr = 1;
            else if (win == 2) m_ptr = 0;
            if (win == 0 || !act[0]) m_cnt = 0;
            else if (win > 0) m_cnt++;
        end
        idle();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_cpu_read();
        test_channel_rr();
        test_lock();
        test_fault();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
